mul_shift_16to32: RTL and testbench
===================================

# mul_shift_16to32

Sequential unsigned shift-and-add multiplier: 16-bit × 16-bit → 32-bit product over a fixed number of clock cycles. It is the widening counterpart of the team's 16→32 divide/shift blocks in the lab2 arithmetic set. It trades area for latency: one adder, one iteration per cycle. A start/busy/done handshake makes it usable from a control FSM or a testbench driver.

## Interface
- `W`, default 16: operand width; product width is 2·W; iteration count is W.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset (sampled on `clk` rising edge).
- `start` input 1: request; sampled only in IDLE.
- `a` input W: multiplicand, unsigned; captured on accepted `start`.
- `b` input W: multiplier, unsigned; captured on accepted `start`.
- `busy` output 1: high from the cycle after `start` is accepted until `done` is asserted.
- `done` output 1: one-cycle pulse; `out` holds a new product in that cycle.
- `out` output 2·W: last completed product; held between operations.

## Operation
- Internal registers:
  - `mcand` (2·W, zero-extended `a`, shifted left each iteration)
  - `mplier` (W, shifted right each iteration)
  - `acc` (2·W)
  - `cnt` (log2(W) bits)
  - `state`
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - If `start`=1: `mcand`←{W'b0,a}, `mplier`←b, `acc`←0, `cnt`←0, `busy`←1, go CALC.
  - Otherwise hold.
- CALC, one iteration per cycle:
  - If `mplier[0]`, `acc`←`acc`+`mcand`.
  - `mcand`←`mcand`<<1; `mplier`←`mplier`>>1; `cnt`←`cnt`+1.
  - When `cnt`=W−1, go FIN.
- FIN: `out`←`acc`, `done`←1, `busy`←0, go IDLE.
- Outside FIN, `done`←0.
- Arithmetic:
  - All unsigned. The 2·W accumulator never overflows, because the max product (2^W−1)^2 < 2^(2W).
  - Addition is plain 2·W-bit with no carry-out.
- Fixed latency: W iterations regardless of operand values. No early exit when `mplier` becomes 0.
- `start` while `busy`=1: ignored. Operands are not re-captured and the running operation is unaffected.
- Changes on `a`/`b` after capture: no effect on the running operation.
- `out` changes only in the FIN cycle, and otherwise holds the previous product.
- Reset:
  - All outputs and state are cleared: `busy`=0, `done`=0, `out`=0, state IDLE, `acc`/`mcand`/`mplier`/`cnt`=0.
  - `rst` takes priority over `start` in the same cycle.
  - `rst` mid-CALC aborts the operation. No `done` is produced for it, and `out` reads 0.

## Timing
- Edge E0: `start`=1 sampled in IDLE. After E0: `busy`=1.
- Edges E1..E(W): the W iterations. After E(W), state = FIN.
- Edge E(W+1): after this edge, `out`=product, `done`=1, `busy`=0, state IDLE.
  - For W=16: `done` is visible after edge 17 counting from the start edge.
- `done` is high for exactly one cycle. It drops after E(W+2) unless reset intervenes.
- Back-to-back operation:
  - `start` held high during the `done` cycle is accepted at E(W+2), so one operation completes every W+2 cycles.
  - `busy` goes high again after E(W+2) and `out` holds the previous product.
- `busy` and `done` are never simultaneously high.

## Test plan
- Reset, then `a`=3, `b`=5, `start` for 1 cycle:
  - `busy`=1 for 17 cycles, then `done`=1 for 1 cycle with `out`=0x0000000F.
  - `out`=0 before the `done` cycle.
- `a`=0xFFFF, `b`=0xFFFF → `out`=0xFFFE0001 at `done`. Then `a`=0x1234, `b`=0 → `out`=0x00000000 at `done`, with the same 17-cycle latency (no early exit).
- During a running 0x0100×0x0100 operation:
  - Pulse `start` with `a`=7, `b`=7 and change `a`/`b` mid-run.
  - Required: a single `done` with `out`=0x00010000, and no second `done`.
- Back-to-back: hold `start`=1 continuously with `a`=2, `b`=3, then `a`=4, `b`=4 presented at the `done` cycle:
  - First `done` shows 0x00000006.
  - Second `done` comes 18 cycles later and shows 0x00000010.
- Reset mid-operation: start 0xABCD×0x0002, assert `rst` for 1 cycle at iteration 8.
  - Required: `busy`=0, `done`=0, `out`=0 after the reset edge, and no `done` follows.
  - A subsequent 9×9 gives `out`=0x00000051.
- Random sweep: 1000 random `a`/`b` pairs compared against a reference `a`×`b`. Each completes in exactly W+1 edges after acceptance, and `busy`/`done` are never both high.

Source files
------------

// File: rtl/mul_shift_16to32.sv
// rtl/mul_shift_16to32.sv - sequential unsigned shift-and-add multiplier, W x W -> 2W
module mul_shift_16to32 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] out
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*W-1:0]   out_q, out_d;

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  // Next-state logic: capture operands in IDLE, one add/shift per CALC cycle, publish in FIN.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{W{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Always W iterations, even once the multiplier has shifted down to zero.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        out_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_mul_shift_16to32.sv
// tb/tb_mul_shift_16to32.sv - self-checking bench for mul_shift_16to32
module tb_mul_shift_16to32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  mul_shift_16to32 #(.W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expected product; busy and done must never overlap.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got out=0x%08h, expected no done", out);
      end else begin
        check("product", out, sb.pop_front());
      end
    end
    if (busy === 1'b1 && done === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
    end
  end

  // One operation: accept, count busy cycles and edges to done, leave bench in the done cycle.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] exp, input bit chk_zero);
    int k;
    int busy_cnt;
    bit zero_ok;
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    zero_ok = (out === 32'h0);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done !== 1'b1) begin
        if (busy === 1'b1) busy_cnt++;
        if (out !== 32'h0) zero_ok = 1'b0;
      end
    end
    check("latency", k, 17);
    check("busy_cycles", busy_cnt, 17);
    if (chk_zero) check("out_zero_before_done", {31'b0, zero_ok}, 32'd1);
  endtask

  initial begin
    int k;
    int d0;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0100, 16'h0100, 32'h0001_0000};
    vecs[4] = '{16'h0009, 16'h0009, 32'h0000_0051};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_out", out, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, i == 0);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("out_held", out, 32'h0000_FFFF);

    // Start pulse and operand changes during a running operation are ignored.
    d0 = n_done;
    a = 16'h0100;
    b = 16'h0100;
    start = 1'b1;
    sb.push_back(32'h0001_0000);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 16'd7;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'h5555;
    b = 16'h3333;
    repeat (40) @(posedge clk);
    #1;
    check("ignored_start_done_count", n_done - d0, 1);

    // Back-to-back with start held high through the done cycle.
    a = 16'd2;
    b = 16'd3;
    start = 1'b1;
    sb.push_back(32'h0000_0006);
    @(posedge clk);
    #1;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_first_latency", k, 17);
    a = 16'd4;
    b = 16'd4;
    sb.push_back(32'h0000_0010);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (done !== 1'b1 && k < 40);
    start = 1'b0;
    check("b2b_gap", k, 18);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of CALC aborts without a done.
    a = 16'hABCD;
    b = 16'h0002;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_out", out, 32'd0);
    d0 = n_done;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    do_op(16'd9, 16'd9, 32'h0000_0051, 1'b1);

    // Random sweep against a widened reference multiply.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, {16'b0, ra} * {16'b0, rb}, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
